// File: rtl/clk_div.sv
// Programmable clock divider: N=0/1 or disabled passes the reference clock through,
// otherwise produces a period of N reference cycles that always begins with its low phase.
module clk_div #(
    parameter int RATIO_WD = 8
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_clk_en,
    input  logic [RATIO_WD-1:0] i_div_ratio,
    output logic                o_div_clk
);

    localparam logic [RATIO_WD-1:0] ONE = {{(RATIO_WD-1){1'b0}}, 1'b1};

    logic [RATIO_WD-1:0] r_count;
    logic                r_div_q;
    logic [RATIO_WD-1:0] r_ratio_q;

    logic                w_div_mode;
    logic                w_ratio_change;
    logic [RATIO_WD-1:0] w_low_len;
    logic [RATIO_WD-1:0] w_high_len;
    logic [RATIO_WD-1:0] w_phase_end;

    assign w_div_mode     = i_clk_en && (i_div_ratio > ONE);
    assign w_ratio_change = (i_div_ratio != r_ratio_q);

    // Odd ratios put the extra cycle in the low phase, so low = ceil(N/2), high = floor(N/2).
    assign w_high_len  = r_ratio_q >> 1;
    assign w_low_len   = (r_ratio_q >> 1) + {{(RATIO_WD-1){1'b0}}, r_ratio_q[0]};
    assign w_phase_end = (r_div_q ? w_high_len : w_low_len) - ONE;

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_div_q   <= 1'b0;
            r_ratio_q <= '0;
        end else if (!w_div_mode) begin
            r_count   <= '0;
            r_div_q   <= 1'b0;
            r_ratio_q <= i_div_ratio;
        end else if (w_ratio_change) begin
            // Restart cleanly on a new ratio so no stale phase can run past its new length.
            r_count   <= '0;
            r_div_q   <= 1'b0;
            r_ratio_q <= i_div_ratio;
        end else if (r_count == w_phase_end) begin
            r_count <= '0;
            r_div_q <= ~r_div_q;
        end else begin
            r_count <= r_count + ONE;
        end
    end

    assign o_div_clk = w_div_mode ? r_div_q : i_ref_clk;

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: bypass pass-through, even/odd division, ratio changes,
// bypass-to-divide entry and mid-run reset, all against hand-derived phase patterns.
module tb_clk_div;

    logic       refClk;
    logic       rst;
    logic       clkEn;
    logic [7:0] divRatio;
    logic       divClk;

    int checkCount = 0;
    int passCount  = 0;

    clk_div #(.RATIO_WD(8)) dut (
        .i_ref_clk  (refClk),
        .i_rst      (rst),
        .i_clk_en   (clkEn),
        .i_div_ratio(divRatio),
        .o_div_clk  (divClk)
    );

    initial refClk = 1'b0;
    always #5 refClk = ~refClk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge so the next rising edge sees them settled.
    task automatic applyStimulus(input logic en, input logic [7:0] ratio, input logic rstVal);
        @(negedge refClk);
        clkEn    = en;
        divRatio = ratio;
        rst      = rstVal;
    endtask

    // In bypass the output must track the reference clock in both half periods.
    task automatic checkBypass(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge refClk);
            #1;
            checkOutput($sformatf("%s_hi%0d", tag, i), divClk, 1'b1);
            @(negedge refClk);
            #1;
            checkOutput($sformatf("%s_lo%0d", tag, i), divClk, 1'b0);
        end
    endtask

    // k counts rising edges from the edge that left the divider at its low-phase start;
    // within each period of n edges the first ceil(n/2) are low, the rest high.
    task automatic checkDivide(input string tag, input int n, input int startK, input int cycles);
        int k;
        int lowLen;
        logic expected;
        lowLen = (n + 1) / 2;
        for (int i = 0; i < cycles; i++) begin
            @(posedge refClk);
            #1;
            k = startK + i;
            expected = ((k % n) < lowLen) ? 1'b0 : 1'b1;
            checkOutput($sformatf("%s_k%0d", tag, k), divClk, expected);
        end
    endtask

    initial begin
        rst      = 1'b1;
        clkEn    = 1'b1;
        divRatio = 8'd0;

        applyStimulus(1'b1, 8'd0, 1'b1);
        checkBypass("rstBypass", 5);
        applyStimulus(1'b1, 8'd0, 1'b0);
        checkBypass("bypassN0", 100);

        applyStimulus(1'b1, 8'd1, 1'b0);
        checkBypass("bypassN1", 10);
        applyStimulus(1'b0, 8'd8, 1'b0);
        checkBypass("bypassEn0", 10);

        // ratio_q holds 8 from bypass, so N=2 is a ratio change and restarts at the first edge.
        applyStimulus(1'b1, 8'd2, 1'b0);
        checkDivide("div2", 2, 0, 20);
        applyStimulus(1'b1, 8'd8, 1'b0);
        checkDivide("div8", 8, 0, 40);

        applyStimulus(1'b1, 8'd7, 1'b0);
        checkDivide("div7", 7, 0, 80);
        applyStimulus(1'b1, 8'd9, 1'b0);
        checkDivide("div9", 9, 0, 100);

        // Same ratio across bypass exit: the last bypass edge already holds the low-phase start.
        applyStimulus(1'b0, 8'd8, 1'b0);
        checkBypass("bypassPre8", 4);
        applyStimulus(1'b1, 8'd8, 1'b0);
        checkDivide("entry8", 8, 1, 24);

        // 100 edges of N=6 leaves the next edge in the high phase; the change must force low.
        applyStimulus(1'b1, 8'd6, 1'b0);
        checkDivide("div6", 6, 0, 100);
        applyStimulus(1'b1, 8'd4, 1'b0);
        checkDivide("switch4", 4, 0, 20);

        applyStimulus(1'b1, 8'd8, 1'b0);
        checkDivide("preRst8", 8, 0, 13);
        applyStimulus(1'b1, 8'd8, 1'b1);
        checkDivide("inRst8", 8, 0, 1);
        // Reset cleared ratio_q, so the first edge after release is again a restart.
        applyStimulus(1'b1, 8'd8, 1'b0);
        checkDivide("postRst8", 8, 0, 32);

        applyStimulus(1'b1, 8'd3, 1'b0);
        checkDivide("div3", 3, 0, 12);
        applyStimulus(1'b1, 8'd255, 1'b0);
        checkDivide("div255", 255, 0, 520);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 The block SHALL have parameter RATIO_WD, default 8, giving the width of the division-ratio input.
REQ-002 The block SHALL have port i_ref_clk, input, 1 bit: the reference clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port i_clk_en, input, 1 bit: the divider enable; when 0 the block bypasses.
REQ-005 The block SHALL have port i_div_ratio, input, RATIO_WD bits: the unsigned division ratio N.
REQ-006 The block SHALL have port o_div_clk, output, 1 bit: the divided clock, or i_ref_clk when bypassing.

Function
REQ-007 The block SHALL hold internally a period counter (RATIO_WD bits), a divided-clock register div_q, and a latched ratio register ratio_q (RATIO_WD bits).
REQ-008 The block SHALL be in divide mode exactly when i_clk_en=1 and i_div_ratio is not 0 and not 1; otherwise it SHALL be in bypass mode.
REQ-009 In bypass mode, o_div_clk SHALL equal i_ref_clk combinationally, with no cycle delay; this is the only combinational path to o_div_clk.
REQ-010 In bypass mode, on each rising edge, the counter SHALL be cleared to 0, div_q SHALL be cleared to 0, and ratio_q SHALL be loaded with i_div_ratio.
REQ-011 In divide mode, o_div_clk SHALL equal div_q.
REQ-012 For even N in divide mode, div_q SHALL toggle every N/2 rising edges, giving a period of N ref cycles at 50% duty.
REQ-013 For odd N in divide mode, the low phase SHALL last (N+1)/2 ref cycles and the high phase (N-1)/2 ref cycles, giving a period of N ref cycles.
REQ-014 The low and high phases for odd N SHALL be implemented by comparing the counter against the current phase length minus 1.
REQ-015 The counter SHALL increment on each rising edge; when it equals the current phase length minus 1, it SHALL clear to 0 and div_q SHALL toggle on that same edge.
REQ-016 Every divided period SHALL start with the low phase.
REQ-017 On entry to divide mode from bypass, the first low phase SHALL begin at the first rising edge in divide mode, with counter=0 and div_q=0.
REQ-018 When i_div_ratio differs from ratio_q while in divide mode, on that edge ratio_q SHALL load i_div_ratio, the counter SHALL clear to 0, and div_q SHALL clear to 0.
REQ-019 After a ratio change, the new period SHALL start at the edge following the change; no truncated-phase runaway is allowed.
REQ-020 Phase arithmetic SHALL be unsigned, RATIO_WD bits wide, and SHALL use N>>1 and (N>>1)+(N&1); N=255 SHALL be supported.
REQ-021 All comparisons SHALL use ratio_q, except for the change detection in REQ-018.

Reset
REQ-022 While i_rst=1 at a rising edge, the counter SHALL clear to 0, div_q SHALL clear to 0, and ratio_q SHALL clear to 0.
REQ-023 Reset SHALL take priority over all other inputs.
REQ-024 During reset, o_div_clk SHALL follow the mode rules: i_ref_clk in bypass, 0 in divide mode.
REQ-025 After reset is deasserted, operation SHALL resume per REQ-017.

Verification
REQ-026 The bench SHALL apply reset with en=1, N=0 -> o_div_clk SHALL equal i_ref_clk for 100 cycles.
REQ-027 The bench SHALL apply en=1, N=1 -> o_div_clk SHALL equal i_ref_clk; en=0 with N=8 -> o_div_clk SHALL equal i_ref_clk.
REQ-028 The bench SHALL apply en=1, N=2 -> period 2 ref cycles, 1 low/1 high; N=8 -> period 8, 4 low/4 high, with the first low phase starting at the first edge after the ratio change.
REQ-029 The bench SHALL apply en=1, N=7 -> period 7, 4 low/3 high; N=9 -> period 9, 5 low/4 high, checked over at least 10 periods.
REQ-030 The bench SHALL run N=6 for 100 cycles, then switch to N=4 mid-phase -> o_div_clk SHALL go low on the next edge, then follow a period of 4, 2 low/2 high, with no phase longer than 3 cycles.
REQ-031 The bench SHALL assert i_rst for 1 cycle mid-run with N=8 -> div_q SHALL be 0 and a fresh 4-low/4-high sequence SHALL start after deassertion.
